// File: rtl/spi_rx_pkg.sv
// Shared types and default sizes for the SPI frame receiver.
//   state_e    : receiver FSM states
//   FRAME_BITS : bits per frame (1 R/W + address + data)
//   ADDR_W     : default address field width
//   DATA_W     : default data field width
//   CNT_SAT    : value at which the bit counter stops counting
package spi_rx_pkg;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StShift
  } state_e;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_SAT    = 17;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage pin synchroniser with edge detection.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d_i        : asynchronous input pin
//   level_o    : synchronised level
//   rise_o     : one-cycle pulse on synchronised 0->1
//   fall_o     : one-cycle pulse on synchronised 1->0
// RESET_VAL sets the idle level of the pin so reset does not look like an edge.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver feeding the pwm_peripheral register bank.
// Synchronises SCLK/COPI/nCS, shifts in MSB-first frames of 1+ADDR_W+DATA_W
// bits and emits one strobe per frame: frame_valid for a well-formed frame,
// frame_err when the bit count at nCS rise is wrong.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   sclk, copi, ncs     : asynchronous SPI pins (ncs active low)
//   frame_valid         : one-cycle pulse, fields below updated
//   frame_write         : R/W bit (1 = write)
//   frame_addr          : address field
//   frame_data          : data field
//   frame_err           : one-cycle pulse, malformed frame dropped
//   busy                : high while a frame is being shifted in
//   err_count           : saturating error count when SPI_FRAME_RX_ERR_CNT_EN
//                         is defined, otherwise constant zero
module spi_frame_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = spi_rx_pkg::ADDR_W,
  parameter int unsigned DATA_W      = spi_rx_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              frame_valid,
  output logic              frame_write,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        err_count
);

  import spi_rx_pkg::*;

  localparam int unsigned FrameBits = 1 + ADDR_W + DATA_W;
  localparam int unsigned CntSat    = FrameBits + 1;
  localparam int unsigned CntW      = $clog2(CntSat + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_lvl;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sclk),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_ncs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ncs),
    .level_o(ncs_lvl),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  // Same depth as the SCLK chain so each sampled bit lines up with its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      copi_sync_q <= '0;
    end else begin
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
    end
  end
  assign copi_lvl = copi_sync_q[SYNC_STAGES-1];

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FrameBits-1:0]  shreg_q, shreg_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      // The nCS chain resets to 1, so its level is only trusted once the
      // chain has been refilled with real samples; the counter tracks that.
      StWaitIdle: begin
        if (!ncs_lvl) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(SYNC_STAGES)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (ncs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        // nCS rise wins over a coincident SCLK rise.
        if (ncs_rise) begin
          state_d = StIdle;
          if (cnt_q == CntW'(FrameBits)) begin
            valid_d                   = 1'b1;
            {write_d, addr_d, data_d} = shreg_q;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FrameBits-2:0], copi_lvl};
          if (cnt_q != CntW'(CntSat)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_write = write_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign busy        = (state_q == StShift);

`ifdef SPI_FRAME_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  // SCLK level and falling edge are not needed in mode 0.
  logic unused_sclk;
  assign unused_sclk = sclk_lvl ^ sclk_fall;

endmodule
